external_in: RTL and testbench
==============================

# external_in

Input port for the SIMPLE CPU, the counterpart of the output port. It synchronizes the 16 board DIP switches and debounces the active-low "enter" push button. Each accepted press captures the switch word into a holding register and raises `ready`. The datapath's IN instruction consumes the word with `inputEnable`, and `stall` holds the CPU until a word is available.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required before the button level is accepted (5 ms at 50 MHz); legal range ≥ 2.
- `SYNC_STAGES`, default 2: flip-flop stages in the synchronizers for `sw` and `btn_n`; legal range ≥ 2.

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low; all state cleared while low.
- `sw`  in  16: raw DIP switches; asynchronous to `clock`.
- `btn_n`  in  1: raw enter button; asynchronous, active-low (0 = pressed).
- `inputEnable`  in  1: CPU IN-read strobe, synchronous to `clock`.
- `dr`  out  16: holding register contents, registered.
- `ready`  out  1: `dr` holds an unread word.
- `overrun`  out  1: sticky; a press was dropped because the previous word was unread.
- `stall`  out  1: combinational, `inputEnable & ~ready`.

## Operation
- Reset state: all synchronizer flops for `sw` are 0 and for `btn_n` are 1 (released). Debounced level = released, debounce counter = 0, `dr` = 16'h0000, `ready` = 0, `overrun` = 0. `stall` = `inputEnable`.
- Synchronizers: `sw` and `btn_n` each pass through `SYNC_STAGES` flops; `sw_s` and `btn_s` are the last stage outputs. No logic acts on the raw inputs.
- Debouncer has two states, RELEASED and PRESSED (the debounced level).
  - While `btn_s` equals the current state, the counter is held at 0.
  - While `btn_s` differs, the counter increments each cycle.
  - On the cycle the counter equals `DEBOUNCE_CYCLES-1` and `btn_s` still differs, the state toggles and the counter returns to 0.
  - A single cycle of agreement resets the counter (glitch rejection). Counter width is `$clog2(DEBOUNCE_CYCLES)`; it never wraps.
- Press event: the edge on which the debouncer moves RELEASED→PRESSED. The PRESSED→RELEASED move produces no event. Holding the button yields exactly one event.
- Capture on a press event:
  - `ready` = 0: `dr` <= `sw_s`, `ready` <= 1.
  - `ready` = 1 and no read this edge: `dr` and `ready` unchanged, `overrun` <= 1.
- Read: an edge with `inputEnable` = 1 and `ready` = 1 consumes the word: `ready` <= 0, `overrun` <= 0. `dr` keeps its value. `inputEnable` with `ready` = 0 has no state effect; it only asserts `stall`.
- Simultaneous read and press with `ready` = 1: the read consumes the old `dr`. The same edge loads `dr` <= `sw_s` with `ready` <= 1 and `overrun` <= 0. No overrun.
- Simultaneous press with `ready` = 0 and `inputEnable` = 1: capture occurs, and `stall` falls in the next cycle. The CPU samples `dr` in that cycle.
- `reset` asserted mid-debounce or mid-stall: the block returns immediately to the reset state, and any partially counted press is discarded.

## Timing
- Press latency: `btn_n` falls and stays low. `btn_s` goes low after `SYNC_STAGES` edges. `ready` rises on the `DEBOUNCE_CYCLES`-th edge after that, i.e. `SYNC_STAGES + DEBOUNCE_CYCLES` edges after the first edge sampling `btn_n` = 0.
- `dr`, `ready` and `overrun` change only on clock edges; `stall` follows `inputEnable` and `ready` combinationally in the same cycle.
- `dr` is stable from the edge `ready` rises until the next capture; the CPU may sample it any cycle `ready` = 1.
- Read handshake: the CPU holds `inputEnable` until `stall` = 0; the consuming edge is the first edge with `inputEnable` = 1 and `stall` = 0.

## Test plan
- Reset and basic capture: bench uses `DEBOUNCE_CYCLES`=4, `SYNC_STAGES`=2. Release `reset`, set `sw`=16'hA5C3, hold `btn_n`=0.
  - `ready` rises exactly 6 edges after the first edge sampling `btn_n`=0.
  - `dr` = 16'hA5C3; after the next `inputEnable` pulse `ready` = 0.
- Glitch rejection: pulse `btn_n` low for 3 cycles and release, repeated 5 times → `ready` stays 0. Then hold low for 5 cycles → exactly one capture.
- Stall: assert `inputEnable` with `ready`=0 → `stall`=1 every cycle. Press with `sw`=16'h0042 → `stall` falls the cycle after `ready` rises. The consuming edge clears `ready`, and `dr`=16'h0042.
- Overrun and coincident read: capture 16'h1111, release, then press with `sw`=16'h2222 and no read → `overrun`=1, `dr`=16'h1111.
  - Read → `overrun`=0, `ready`=0.
  - Set up a press whose accept edge coincides with `inputEnable`=1 and `ready`=1 → `dr`=new `sw`, `ready`=1, `overrun`=0.
- Held button: keep `btn_n`=0 for 50 cycles after capture and read → no second capture. Release for 5 cycles, press again → second capture.
- Async reset mid-operation: drop `reset` at debounce count 2, then again with `ready`=1. Both times `dr`=0, `ready`=0 and `overrun`=0 before the next clock edge; no capture follows the reset release until a full new press.

Source files
------------

// File: rtl/external_in.sv
// Input port for the SIMPLE CPU: synchronises the DIP switches, debounces the
// active-low enter button and holds one captured word for the IN instruction.
module external_in #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] sw,
    input  logic        btn_n,
    input  logic        inputEnable,
    output logic [15:0] dr,
    output logic        ready,
    output logic        overrun,
    output logic        stall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } db_state_t;

    logic [SYNC_STAGES-1:0][15:0] sw_sync_q, sw_sync_d;
    logic [SYNC_STAGES-1:0]       btn_sync_q, btn_sync_d;
    logic [15:0]                  sw_s;
    logic                         btn_s;

    db_state_t                    db_state_q, db_state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         press_evt;

    logic [15:0]                  dr_q, dr_d;
    logic                         ready_q, ready_d;
    logic                         overrun_q, overrun_d;
    logic                         read_evt;

    // Each synchroniser shifts one stage per clock; stage 0 samples the raw pin.
    always_comb begin
        sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], sw};
        btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], btn_n};
    end

    assign sw_s  = sw_sync_q[SYNC_STAGES-1];
    assign btn_s = btn_sync_q[SYNC_STAGES-1];

    // The counter only runs while the synchronised button disagrees with the
    // debounced level; any agreeing cycle throws away the partial count.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        db_state_d = db_state_q;
        cnt_d      = cnt_q;
        press_evt  = 1'b0;
        if ((btn_s == 1'b0) == (db_state_q == PRESSED)) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d      = '0;
            db_state_d = (db_state_q == PRESSED) ? RELEASED : PRESSED;
            press_evt  = (db_state_q == RELEASED);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // A read and a press on the same edge hand the old word to the CPU and
    // load the new one, so no overrun is flagged.
    always_comb begin
        dr_d      = dr_q;
        ready_d   = ready_q;
        overrun_d = overrun_q;
        read_evt  = inputEnable & ready_q;
        if (read_evt) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (press_evt) begin
            if (!ready_q || read_evt) begin
                dr_d    = sw_s;
                ready_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the button synchroniser resets to 1 (released) so reset release never looks like a press.
            sw_sync_q  <= '0;
            btn_sync_q <= '1;
            db_state_q <= RELEASED;
            cnt_q      <= '0;
            dr_q       <= '0;
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sw_sync_q  <= sw_sync_d;
            btn_sync_q <= btn_sync_d;
            db_state_q <= db_state_d;
            cnt_q      <= cnt_d;
            dr_q       <= dr_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
        end
    end

    assign dr      = dr_q;
    assign ready   = ready_q;
    assign overrun = overrun_q;
    assign stall   = inputEnable & ~ready_q;

endmodule

// File: tb/tb_external_in.sv
// Self-checking bench for external_in: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_external_in;

    localparam int DEB  = 4;
    localparam int SYNC = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] sw = '0;
    logic        btn_n = 1'b1;
    logic        inputEnable = 1'b0;
    logic [15:0] dr;
    logic        ready, overrun, stall;

    int checks = 0;
    int errors = 0;

    external_in #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
        .clock(clock), .reset(reset), .sw(sw), .btn_n(btn_n),
        .inputEnable(inputEnable), .dr(dr), .ready(ready),
        .overrun(overrun), .stall(stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pins delayed by SYNC samples; the level flips once the
    // last DEB synchronised samples all disagree with it.
    bit          btn_pipe[$];
    logic [15:0] sw_pipe[$];
    bit          hist[$];
    bit          m_level;
    logic [15:0] m_dr;
    bit          m_ready, m_ovr;
    bit          bs, evt, rd;
    logic [15:0] ss;
    int          ndiff;

    task automatic model_reset();
        btn_pipe.delete();
        sw_pipe.delete();
        hist.delete();
        for (int i = 0; i < SYNC; i++) begin
            btn_pipe.push_back(1'b1);
            sw_pipe.push_back(16'h0);
        end
        m_level = 1'b0;
        m_dr    = 16'h0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            model_reset();
        end else begin
            bs = btn_pipe.pop_front();
            ss = sw_pipe.pop_front();
            btn_pipe.push_back(btn_n);
            sw_pipe.push_back(sw);
            evt = 1'b0;
            hist.push_back(!bs);
            if (hist.size() > DEB) void'(hist.pop_front());
            ndiff = 0;
            foreach (hist[i]) if (hist[i] != m_level) ndiff++;
            if (ndiff == DEB) begin
                m_level = !m_level;
                hist.delete();
                evt = m_level;
            end
            rd = inputEnable && m_ready;
            if (rd) begin
                m_ready = 1'b0;
                m_ovr   = 1'b0;
            end
            if (evt) begin
                if (!m_ready) begin
                    m_dr    = ss;
                    m_ready = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    end

    always begin
        @(negedge clock);
        #2;
        check("model_dr", {16'h0, dr}, {16'h0, m_dr});
        check("model_ready", {31'h0, ready}, {31'h0, m_ready});
        check("model_overrun", {31'h0, overrun}, {31'h0, m_ovr});
        check("model_stall", {31'h0, stall}, {31'h0, inputEnable & ~m_ready});
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        check({name, "_ready_timeout"}, {31'h0, ready}, 32'h1);
    endtask

    task automatic press(input logic [15:0] val, input string name);
        sw    = val;
        btn_n = 1'b0;
        wait_ready(name);
    endtask

    task automatic release_btn();
        btn_n = 1'b1;
        repeat (SYNC + DEB + 2) tick();
    endtask

    task automatic read_pulse();
        inputEnable = 1'b1;
        tick();
        inputEnable = 1'b0;
    endtask

    // Counts edges from the first edge sampling btn_n = 0 until ready is seen.
    task automatic measure_latency(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1;
            n = i;
            if (ready) break;
        end
        @(negedge clock);
    endtask

    task automatic wait_overrun(input string name);
        int n;
        n = 0;
        while (!overrun && n < 40) begin
            tick();
            n++;
        end
        check({name, "_overrun_timeout"}, {31'h0, overrun}, 32'h1);
    endtask

    int lat;
    int run;

    initial begin
        #1;
        check("rst_dr", {16'h0, dr}, 32'h0);
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        inputEnable = 1'b1;
        #1;
        check("rst_stall_follows_ie", {31'h0, stall}, 32'h1);
        inputEnable = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        tick();

        // Basic capture and latency
        sw    = 16'hA5C3;
        btn_n = 1'b0;
        measure_latency(lat);
        check("press_latency", lat, SYNC + DEB);
        check("capture_dr", {16'h0, dr}, 32'h0000A5C3);
        read_pulse();
        check("read_clears_ready", {31'h0, ready}, 32'h0);
        release_btn();

        // Glitch rejection
        sw = 16'h0BAD;
        repeat (5) begin
            btn_n = 1'b0;
            repeat (3) tick();
            btn_n = 1'b1;
            repeat (3) tick();
        end
        check("glitch_no_ready", {31'h0, ready}, 32'h0);
        btn_n = 1'b0;
        repeat (5) tick();
        btn_n = 1'b1;
        repeat (SYNC + DEB + 2) tick();
        check("glitch_one_capture", {31'h0, ready}, 32'h1);
        check("glitch_no_overrun", {31'h0, overrun}, 32'h0);
        check("glitch_dr", {16'h0, dr}, 32'h00000BAD);
        read_pulse();

        // Stall handshake
        inputEnable = 1'b1;
        repeat (3) begin
            tick();
            check("stall_while_empty", {31'h0, stall}, 32'h1);
        end
        press(16'h0042, "stall");
        check("stall_low_when_ready", {31'h0, stall}, 32'h0);
        check("stall_dr", {16'h0, dr}, 32'h00000042);
        tick();
        check("stall_consumed", {31'h0, ready}, 32'h0);
        check("stall_dr_kept", {16'h0, dr}, 32'h00000042);
        inputEnable = 1'b0;
        release_btn();

        // Overrun and coincident read
        press(16'h1111, "ovr_a");
        release_btn();
        sw    = 16'h2222;
        btn_n = 1'b0;
        wait_overrun("ovr_b");
        check("ovr_dr_kept", {16'h0, dr}, 32'h00001111);
        release_btn();
        read_pulse();
        check("ovr_read_clears", {31'h0, overrun}, 32'h0);
        check("ovr_read_ready", {31'h0, ready}, 32'h0);
        press(16'h3333, "ovr_c");
        release_btn();
        sw    = 16'h4444;
        btn_n = 1'b0;
        wait_overrun("ovr_d");
        release_btn();
        sw    = 16'h5555;
        btn_n = 1'b0;
        repeat (SYNC + DEB - 1) tick();
        inputEnable = 1'b1;
        tick();
        inputEnable = 1'b0;
        check("coinc_dr", {16'h0, dr}, 32'h00005555);
        check("coinc_ready", {31'h0, ready}, 32'h1);
        check("coinc_overrun", {31'h0, overrun}, 32'h0);
        read_pulse();
        release_btn();

        // Held button gives one event
        press(16'h6666, "held");
        read_pulse();
        repeat (50) tick();
        check("held_no_second", {31'h0, ready}, 32'h0);
        check("held_no_overrun", {31'h0, overrun}, 32'h0);
        btn_n = 1'b1;
        repeat (5) tick();
        press(16'h7777, "held_again");
        check("held_again_dr", {16'h0, dr}, 32'h00007777);
        read_pulse();
        release_btn();

        // Asynchronous reset mid-debounce and with a word held
        sw    = 16'h8888;
        btn_n = 1'b0;
        repeat (SYNC + 2) tick();
        #1 reset = 1'b0;
        #1;
        check("rst_mid_dr", {16'h0, dr}, 32'h0);
        check("rst_mid_ready", {31'h0, ready}, 32'h0);
        @(negedge clock);
        #1 reset = 1'b1;
        measure_latency(lat);
        check("rst_full_new_press", lat, SYNC + DEB);
        #1 reset = 1'b0;
        #1;
        check("rst_ready_dr", {16'h0, dr}, 32'h0);
        check("rst_ready_ready", {31'h0, ready}, 32'h0);
        check("rst_ready_overrun", {31'h0, overrun}, 32'h0);
        btn_n = 1'b1;
        @(negedge clock);
        #1 reset = 1'b1;
        repeat (10) tick();
        check("rst_no_capture", {31'h0, ready}, 32'h0);

        // Randomised traffic against the model
        repeat (400) begin
            btn_n = 1'($urandom_range(0, 1));
            run   = $urandom_range(1, 8);
            repeat (run) begin
                sw          = 16'($urandom);
                inputEnable = ($urandom_range(0, 3) == 0);
                tick();
            end
            if ($urandom_range(0, 99) == 0) begin
                #1 reset = 1'b0;
                @(negedge clock);
                #1 reset = 1'b1;
            end
        end
        inputEnable = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
